// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with a prefetch FIFO feeding IF/ID.
// Define IF_MISALIGN_TRAP_EN to trap misaligned redirect targets instead of aligning them.
module if_fetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          BUF_DEPTH       = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        br_i,
    input  logic [31:0] bt_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o,
    output logic        misalign_o
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, pc_q, pc_d, inst_q, inst_d, target;
    logic [63:0]   fifo_q [BUF_DEPTH];
    logic [63:0]   head;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] infl_q, infl_d, disc_q, disc_d;
    logic          valid_q, valid_d, mis_q, mis_d, mis_br, issue, push, pop, kill;

`ifdef IF_MISALIGN_TRAP_EN
    assign mis_br = br_i && bt_i[1:0] != 2'b00;
    assign target = bt_i;
`else
    assign mis_br = 1'b0;
    assign target = bt_i & 32'hFFFF_FFFC;
`endif

    // Credit rule: in-flight words always have a FIFO slot reserved.
    assign imem_req_o  = !rst && !br_i && !mis_q && int'(infl_q) < MAX_OUTSTANDING
                         && int'(cnt_q) + int'(infl_q) < BUF_DEPTH;
    assign imem_addr_o = fetch_pc_q;
    assign issue       = imem_req_o && imem_gnt_i;
    assign push        = imem_rvalid_i && disc_q == '0 && !br_i;
    assign pop         = !br_i && !stall_i && cnt_q != '0;
    assign kill        = br_i || mis_q;
    assign head        = fifo_q[rd_q];
    assign pc_o        = pc_q;
    assign inst_o      = inst_q;
    assign valid_o     = valid_q;
    assign misalign_o  = mis_q;

    always_comb begin
        fetch_pc_d = br_i ? target : issue ? fetch_pc_q + 32'd4 : fetch_pc_q;
        resp_pc_d  = br_i ? target : push ? resp_pc_q + 32'd4 : resp_pc_q;
        infl_d     = infl_q + IW'(issue) - IW'(imem_rvalid_i);
        disc_d     = br_i ? infl_q - IW'(imem_rvalid_i)
                   : (imem_rvalid_i && disc_q != '0) ? disc_q - IW'(1) : disc_q;
        wr_d       = br_i ? '0 : push ? wr_q + PW'(1) : wr_q;
        rd_d       = br_i ? '0 : pop ? rd_q + PW'(1) : rd_q;
        cnt_d      = br_i ? '0 : cnt_q + CW'(push) - CW'(pop);
        mis_d      = mis_q || mis_br;
        valid_d    = kill ? 1'b0 : stall_i ? valid_q : pop;
        pc_d       = kill ? 32'h0 : stall_i ? pc_q : pop ? head[63:32] : 32'h0;
        inst_d     = kill ? 32'h0 : stall_i ? inst_q : pop ? head[31:0] : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            infl_q     <= '0;
            disc_q     <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            mis_q      <= 1'b0;
            valid_q    <= 1'b0;
            pc_q       <= 32'h0;
            inst_q     <= 32'h0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            infl_q     <= infl_d;
            disc_q     <= disc_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            mis_q      <= mis_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_q] <= {resp_pc_q, imem_rdata_i};
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed checks of if_fetch against an in-order memory model.
module tb_if_fetch;
    logic clk = 1'b0, rst = 1'b1, gnt = 1'b0, rvalid = 1'b0, stall = 1'b0, br = 1'b0, hold = 1'b0;
    logic [31:0] rdata = 32'h0, bt = 32'h0, addr, pc, inst;
    logic req, valid, mis;
    logic [31:0] q [$];
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk(clk), .rst(rst), .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .stall_i(stall), .br_i(br), .bt_i(bt),
        .pc_o(pc), .inst_o(inst), .valid_o(valid), .misalign_o(mis)
    );

    // Memory returns ~addr one cycle after issue; hold parks responses in order.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            rvalid <= 1'b0;
        end else begin
            if (req && gnt) q.push_back(addr);
            if (!hold && q.size() > 0) begin
                rvalid <= 1'b1;
                rdata  <= ~q.pop_front();
            end else rvalid <= 1'b0;
        end
    end

    task automatic do_reset(input logic g);
        @(negedge clk);
        rst = 1'b1; gnt = 1'b0; stall = 1'b0; br = 1'b0; bt = 32'h0; hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; gnt = g;
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", req); end
        n_cmp++; if (addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", addr); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", pc); end
        n_cmp++; if (inst !== 32'h0) begin n_bad++; $display("FAIL reset_inst: got %h want 0", inst); end
        n_cmp++; if (mis !== 1'b0) begin n_bad++; $display("FAIL reset_mis: got %b want 0", mis); end
    endtask

    task automatic test_stream;
        logic [31:0] ep, ei;
        do_reset(1'b1);
        for (int n = 0; n < 8; n++) begin
            ep = n >= 3 ? 32'(4 * (n - 3)) : 32'h0;
            ei = n >= 3 ? ~ep : 32'h0;
            n_cmp++; if (req !== 1'b1) begin n_bad++; $display("FAIL stream_req c%0d: got %b want 1", n, req); end
            n_cmp++; if (addr !== 32'(4 * n)) begin n_bad++; $display("FAIL stream_addr c%0d: got %h want %h", n, addr, 32'(4 * n)); end
            n_cmp++; if (valid !== (n >= 3)) begin n_bad++; $display("FAIL stream_valid c%0d: got %b want %b", n, valid, n >= 3); end
            n_cmp++; if (pc !== ep) begin n_bad++; $display("FAIL stream_pc c%0d: got %h want %h", n, pc, ep); end
            n_cmp++; if (inst !== ei) begin n_bad++; $display("FAIL stream_inst c%0d: got %h want %h", n, inst, ei); end
            @(negedge clk);
        end
    endtask

    task automatic test_gnt_low;
        do_reset(1'b0);
        for (int n = 0; n < 5; n++) begin
            n_cmp++; if (req !== 1'b1) begin n_bad++; $display("FAIL gnt_req c%0d: got %b want 1", n, req); end
            n_cmp++; if (addr !== 32'h0) begin n_bad++; $display("FAIL gnt_addr c%0d: got %h want 0", n, addr); end
            n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL gnt_valid c%0d: got %b want 0", n, valid); end
            @(negedge clk);
        end
        gnt = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL gnt_first_valid: got %b want 1", valid); end
        n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL gnt_first_pc: got %h want 0", pc); end
        n_cmp++; if (inst !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL gnt_first_inst: got %h want ffffffff", inst); end
    endtask

    task automatic test_stall;
        logic [31:0] ep;
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        for (int n = 3; n <= 14; n++) begin
            ep = n <= 7 ? 32'h0 : 32'(4 * (n - 7));
            n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid c%0d: got %b want 1", n, valid); end
            n_cmp++; if (pc !== ep) begin n_bad++; $display("FAIL stall_pc c%0d: got %h want %h", n, pc, ep); end
            n_cmp++; if (inst !== ~ep) begin n_bad++; $display("FAIL stall_inst c%0d: got %h want %h", n, inst, ~ep); end
            if (n <= 8) begin
                n_cmp++; if (req !== (n == 3 || n == 4 || n == 8)) begin n_bad++; $display("FAIL stall_req c%0d: got %b want %b", n, req, n == 3 || n == 4 || n == 8); end
            end
            if (n == 8) begin
                n_cmp++; if (addr !== 32'h14) begin n_bad++; $display("FAIL stall_addr: got %h want 00000014", addr); end
            end
            stall = n <= 6;
            @(negedge clk);
        end
    endtask

    task automatic test_branch;
        do_reset(1'b1);
        hold = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL br_req_full: got %b want 0", req); end
        br = 1'b1; bt = 32'h100;
        @(negedge clk);
        br = 1'b0; hold = 1'b0;
        #1;
        for (int n = 3; n <= 9; n++) begin
            if (n <= 5) begin
                n_cmp++; if (req !== (n == 5)) begin n_bad++; $display("FAIL br_req c%0d: got %b want %b", n, req, n == 5); end
            end
            if (n == 5) begin
                n_cmp++; if (addr !== 32'h100) begin n_bad++; $display("FAIL br_addr: got %h want 00000100", addr); end
            end
            n_cmp++; if (valid !== (n >= 8)) begin n_bad++; $display("FAIL br_valid c%0d: got %b want %b", n, valid, n >= 8); end
            if (n >= 8) begin
                n_cmp++; if (pc !== 32'(32'h100 + 4 * (n - 8))) begin n_bad++; $display("FAIL br_pc c%0d: got %h want %h", n, pc, 32'(32'h100 + 4 * (n - 8))); end
                n_cmp++; if (inst !== ~32'(32'h100 + 4 * (n - 8))) begin n_bad++; $display("FAIL br_inst c%0d: got %h want %h", n, inst, ~32'(32'h100 + 4 * (n - 8))); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_br_stall_rvalid;
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL bsr_pre_valid: got %b want 1", valid); end
        stall = 1'b1; br = 1'b1; bt = 32'h200;
        #1;
        n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL bsr_req_on_br: got %b want 0", req); end
        @(negedge clk);
        stall = 1'b0; br = 1'b0;
        #1;
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL bsr_valid: got %b want 0", valid); end
        n_cmp++; if (pc !== 32'h0 || inst !== 32'h0) begin n_bad++; $display("FAIL bsr_bubble: got pc %h inst %h want 0 0", pc, inst); end
        n_cmp++; if (req !== 1'b1 || addr !== 32'h200) begin n_bad++; $display("FAIL bsr_target_req: got %b %h want 1 00000200", req, addr); end
        repeat (3) @(negedge clk);
        n_cmp++; if (valid !== 1'b1 || pc !== 32'h200) begin n_bad++; $display("FAIL bsr_first: got %b %h want 1 00000200", valid, pc); end
        n_cmp++; if (inst !== ~32'h200) begin n_bad++; $display("FAIL bsr_inst: got %h want %h", inst, ~32'h200); end
    endtask

    task automatic test_misalign;
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        br = 1'b1; bt = 32'h102;
        @(negedge clk);
        br = 1'b0;
        #1;
`ifdef IF_MISALIGN_TRAP_EN
        for (int n = 4; n <= 8; n++) begin
            n_cmp++; if (mis !== 1'b1) begin n_bad++; $display("FAIL mis_flag c%0d: got %b want 1", n, mis); end
            n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL mis_req c%0d: got %b want 0", n, req); end
            n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL mis_valid c%0d: got %b want 0", n, valid); end
            @(negedge clk);
        end
`else
        n_cmp++; if (mis !== 1'b0) begin n_bad++; $display("FAIL mis_flag: got %b want 0", mis); end
        n_cmp++; if (req !== 1'b1 || addr !== 32'h100) begin n_bad++; $display("FAIL mis_aligned_req: got %b %h want 1 00000100", req, addr); end
        repeat (3) @(negedge clk);
        n_cmp++; if (valid !== 1'b1 || pc !== 32'h100) begin n_bad++; $display("FAIL mis_resume: got %b %h want 1 00000100", valid, pc); end
`endif
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (mis !== 1'b0) begin n_bad++; $display("FAIL mis_rst_flag: got %b want 0", mis); end
        n_cmp++; if (valid !== 1'b0 || req !== 1'b0) begin n_bad++; $display("FAIL mis_rst_state: got valid %b req %b want 0 0", valid, req); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_gnt_low();
        test_stall();
        test_branch();
        test_br_stall_rvalid();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
